// File: rtl/peri_uart_pkg.sv
// Shared types and constants for the transmit-only peripheral-bus UART.
package peri_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_BAUD   = 2'd3;

   localparam int unsigned ST_IRQ   = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_FULL  = 2;
   localparam int unsigned ST_BUSY  = 3;
   localparam int unsigned ST_OVF   = 4;

   localparam int unsigned CTRL_TX_EN  = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;

endpackage

// File: rtl/peri_uart_if.sv
// Local register port forwarded by the peripheral bus controller.
interface peri_uart_if;
   logic [1:0]  addr;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] wdata;
   logic [15:0] rdata;

   modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
   modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/peri_sync_fifo.sv
// Synchronous circular-buffer FIFO; pushes when full and pops when empty are ignored.
module peri_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_bar,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == FULL_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: emptying the pointers/count discards contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/peri_uart_tx.sv
// Transmit-only UART: register file, byte FIFO and 8N1 serialiser with drain interrupt.
module peri_uart_tx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd15
) (
   input  logic       clk,
   input  logic       reset_bar,
   peri_uart_if.slave bus,
   output logic       irq_o,
   output logic       tx_o
);
   import peri_uart_pkg::*;

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count_unused;

   uart_state_t   state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;

   logic [1:0]    ctrl_q;
   logic [15:0]   baud_q;
   logic          ovf_q, irq_q;
   logic          start_frame, bit_done, busy, status_rd;

   assign fifo_push   = bus.wr_en && (bus.addr == REG_DATA);
   assign status_rd   = bus.rd_en && (bus.addr == REG_STATUS);
   assign busy        = (state_q != IDLE);
   assign start_frame = (state_q == IDLE) && ctrl_q[CTRL_TX_EN] && !fifo_empty;
   // >= rather than == so a mid-frame BAUD shrink ends the bit at once.
   assign bit_done    = (cnt_q >= baud_q);
   assign irq_o       = irq_q;

   peri_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_bar (reset_bar),
      .push_i    (fifo_push),
      .pop_i     (fifo_pop),
      .din_i     (bus.wdata[7:0]),
      .dout_o    (fifo_dout),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count_unused)
   );

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            if (start_frame) begin
               state_d = START;
               cnt_d   = '0;
               shift_d = fifo_dout;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = start_frame;
      case (state_q)
         START:   tx_o = 1'b0;
         DATA:    tx_o = shift_q[0];
         default: tx_o = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         ctrl_q <= '0;
         baud_q <= DIV_RESET;
         ovf_q  <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         if (bus.wr_en && (bus.addr == REG_CTRL)) ctrl_q <= bus.wdata[1:0];
         if (bus.wr_en && (bus.addr == REG_BAUD)) baud_q <= bus.wdata;
         // An overflowing write beats a simultaneous STATUS read-clear.
         if (fifo_push && fifo_full) ovf_q <= 1'b1;
         else if (status_rd)         ovf_q <= 1'b0;
         irq_q <= ctrl_q[CTRL_IRQ_EN] && fifo_empty && !busy;
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         REG_STATUS: begin
            bus.rdata[ST_IRQ]   = irq_q;
            bus.rdata[ST_EMPTY] = fifo_empty;
            bus.rdata[ST_FULL]  = fifo_full;
            bus.rdata[ST_BUSY]  = busy;
            bus.rdata[ST_OVF]   = ovf_q;
         end
         REG_CTRL: bus.rdata[1:0] = ctrl_q;
         REG_BAUD: bus.rdata      = baud_q;
         default:  bus.rdata      = '0;
      endcase
   end
endmodule

// File: tb/tb_peri_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes tx frames and compares.
module tb_peri_uart_tx;
   import peri_uart_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset_bar = 1'b0;
   logic irq_o, tx_o;

   peri_uart_if bus ();

   peri_uart_tx #(
      .FIFO_DEPTH (DEPTH),
      .DIV_RESET  (16'd15)
   ) dut (
      .clk       (clk),
      .reset_bar (reset_bar),
      .bus       (bus),
      .irq_o     (irq_o),
      .tx_o      (tx_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_q [$];
   int         start_q [$];
   bit         mon_en = 1'b0;
   int         cur_baud = 15;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic peek(input logic [1:0] a, output logic [15:0] d);
      bus.addr = a;
      #1 d = bus.rdata;
   endtask

   task automatic rd_pulse(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.addr = a; bus.rd_en = 1'b1;
      #1 d = bus.rdata;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   function automatic logic [15:0] status_of(input bit ovf, input bit bsy, input bit full,
                                              input bit empty, input bit irq);
      return {11'd0, ovf, bsy, full, empty, irq};
   endfunction

   task automatic wait_drain(input string name);
      int n;
      logic [15:0] s;
      n = 0;
      do begin
         @(negedge clk);
         peek(REG_STATUS, s);
         n++;
      end while ((exp_q.size() != 0 || s[ST_BUSY]) && n < 4000);
      check({name, " drain"}, {31'd0, (exp_q.size() == 0 && !s[ST_BUSY])}, 32'd1);
   endtask

   // Line monitor: each bit lasts baud+1 cycles; sample the middle of each one.
   initial begin
      int b, pos, tgt;
      logic [7:0] got;
      forever begin
         @(negedge clk);
         if (mon_en && tx_o === 1'b0) begin
            b = cur_baud;
            pos = 0;
            got = '0;
            start_q.push_back(cyc);
            for (int k = 0; k < 10; k++) begin
               tgt = k * (b + 1) + b / 2;
               while (pos < tgt) begin
                  @(negedge clk);
                  pos++;
               end
               if (k == 0)      check("start bit", {31'd0, tx_o}, 32'd0);
               else if (k <= 8) got[k-1] = tx_o;
               else             check("stop bit", {31'd0, tx_o}, 32'd1);
            end
            if (exp_q.size() == 0) check("unexpected frame", {24'd0, got}, 32'hFFFF_FFFF);
            else                   check("frame byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s;
      logic [7:0]  x;
      int occ, n, b, ebit, miss;
      bit ovf;

      bus.addr = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wdata = '0;
      repeat (3) @(negedge clk);
      reset_bar = 1'b1;
      @(negedge clk);

      peek(REG_STATUS, s); check("reset STATUS", {16'd0, s}, 32'h0002);
      peek(REG_CTRL, s);   check("reset CTRL", {16'd0, s}, 32'd0);
      peek(REG_BAUD, s);   check("reset BAUD", {16'd0, s}, 32'd15);
      peek(REG_DATA, s);   check("reset DATA", {16'd0, s}, 32'd0);
      check("reset tx", {31'd0, tx_o}, 32'd1);
      check("reset irq", {31'd0, irq_o}, 32'd0);
      mon_en = 1'b1;

      // Cycle-exact frame of 0xA5 at 4 cycles per bit
      wr(REG_BAUD, 16'd3); cur_baud = 3;
      wr(REG_CTRL, 16'd1);
      exp_q.push_back(8'hA5);
      wr(REG_DATA, 16'h00A5);
      check("pre-frame tx", {31'd0, tx_o}, 32'd1);
      x = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n = i / 4;
         ebit = (n == 0) ? 0 : (n == 9) ? 1 : int'(x[n-1]);
         check($sformatf("A5 tx cycle %0d", i), {31'd0, tx_o}, ebit);
         peek(REG_STATUS, s);
         check($sformatf("A5 busy cycle %0d", i), {31'd0, s[ST_BUSY]}, 32'd1);
      end
      @(negedge clk);
      check("A5 post tx", {31'd0, tx_o}, 32'd1);
      peek(REG_STATUS, s);
      check("A5 post busy", {31'd0, s[ST_BUSY]}, 32'd0);
      wait_drain("A5");

      // Overflow: five writes into a four-deep queue while transmit is disabled
      wr(REG_CTRL, 16'd0);
      occ = 0; ovf = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (occ < int'(DEPTH)) begin
            exp_q.push_back(8'h11 + 8'(i));
            occ++;
         end else ovf = 1'b1;
         wr(REG_DATA, 16'hAB00 | (16'h11 + 16'(i)));
      end
      peek(REG_STATUS, s);
      check("ovf STATUS", {16'd0, s}, {16'd0, status_of(ovf, 0, occ == int'(DEPTH), occ == 0, 0)});
      rd_pulse(REG_STATUS, s);
      check("ovf read-clear data", {31'd0, s[ST_OVF]}, 32'd1);
      peek(REG_STATUS, s);
      check("ovf cleared", {31'd0, s[ST_OVF]}, 32'd0);
      start_q.delete();
      wr(REG_CTRL, 16'd1);
      wait_drain("ovf");
      check("ovf frame count", start_q.size(), 32'd4);
      for (int i = 0; i + 1 < start_q.size(); i++)
         check($sformatf("frame gap %0d", i), start_q[i+1] - start_q[i], 10 * (cur_baud + 1) + 1);

      // Drain interrupt timing
      wr(REG_CTRL, 16'd3);
      check("irq after ctrl edge", {31'd0, irq_o}, 32'd0);
      @(negedge clk);
      check("irq one cycle later", {31'd0, irq_o}, 32'd1);
      peek(REG_STATUS, s);
      check("STATUS irq bit", {16'd0, s}, 32'h0003);
      exp_q.push_back(8'h00);
      wr(REG_DATA, 16'h0000);
      check("irq before pop", {31'd0, irq_o}, 32'd1);
      @(negedge clk);
      check("irq after pop", {31'd0, irq_o}, 32'd0);
      n = 0;
      do begin
         @(negedge clk);
         peek(REG_STATUS, s);
         n++;
      end while (s[ST_BUSY] && n < 200);
      check("irq frame end seen", {31'd0, s[ST_BUSY]}, 32'd0);
      check("irq at idle entry", {31'd0, irq_o}, 32'd0);
      @(negedge clk);
      check("irq after stop", {31'd0, irq_o}, 32'd1);
      wait_drain("irq");

      // Clear tx_en during data bit 3
      wr(REG_CTRL, 16'd1);
      x = 8'($urandom);
      exp_q.push_back(x);
      wr(REG_DATA, {8'd0, x});
      n = 0;
      while (tx_o !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("txen frame started", {31'd0, tx_o}, 32'd0);
      repeat (15) @(negedge clk);
      wr(REG_CTRL, 16'd0);
      exp_q.push_back(8'h7E);
      wr(REG_DATA, 16'h007E);
      n = 0;
      do begin
         @(negedge clk);
         peek(REG_STATUS, s);
         n++;
      end while (s[ST_BUSY] && n < 200);
      miss = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1) miss++;
      end
      check("txen held idle", miss, 32'd0);
      peek(REG_STATUS, s);
      check("txen queued", {16'd0, s}, {16'd0, status_of(0, 0, 0, 0, 0)});
      check("txen queue depth", exp_q.size(), 32'd1);
      wr(REG_CTRL, 16'd1);
      wait_drain("txen");

      // Random batches at random baud settings
      for (int it = 0; it < 6; it++) begin
         b = int'($urandom_range(0, 5));
         wr(REG_CTRL, 16'd0);
         wr(REG_BAUD, 16'(b)); cur_baud = b;
         n = int'($urandom_range(1, 6));
         occ = 0; ovf = 1'b0;
         for (int i = 0; i < n; i++) begin
            x = 8'($urandom);
            if (occ < int'(DEPTH)) begin
               exp_q.push_back(x);
               occ++;
            end else ovf = 1'b1;
            wr(REG_DATA, {8'($urandom), x});
         end
         peek(REG_STATUS, s);
         check($sformatf("rand %0d STATUS", it), {16'd0, s},
               {16'd0, status_of(ovf, 0, occ == int'(DEPTH), occ == 0, 0)});
         rd_pulse(REG_STATUS, s);
         wr(REG_CTRL, 16'd1);
         wait_drain($sformatf("rand %0d", it));
      end

      // Asynchronous reset mid-frame
      mon_en = 1'b0;
      wr(REG_BAUD, 16'd3); cur_baud = 3;
      wr(REG_CTRL, 16'd1);
      wr(REG_DATA, 16'h005A);
      n = 0;
      while (tx_o !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (9) @(negedge clk);
      peek(REG_STATUS, s);
      check("pre-reset busy", {31'd0, s[ST_BUSY]}, 32'd1);
      #1 reset_bar = 1'b0;
      #1 check("async reset tx", {31'd0, tx_o}, 32'd1);
      repeat (2) @(negedge clk);
      reset_bar = 1'b1;
      @(negedge clk);
      peek(REG_STATUS, s); check("post-reset STATUS", {16'd0, s}, 32'h0002);
      peek(REG_BAUD, s);   check("post-reset BAUD", {16'd0, s}, 32'd15);
      check("post-reset tx", {31'd0, tx_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
